// File: rtl/led_grid_pkg.sv
// led_grid_pkg: LED mode/entry types and ledNo width shared by the LED grid panel
package led_grid_pkg;
  localparam int LEDNO_W = 8;
  typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, BLINK_N = 2'd3} ledMode_t;
  typedef struct packed {
    logic [LEDNO_W-1:0] ledNo;
    ledMode_t mode;
    logic [11:0] rgb;
  } ledEntry_t;
endpackage

// File: rtl/grid_axis_cnt.sv
// grid_axis_cnt: divider-free tile tracker for one axis (in: pos, adv strobe; out: tile index, inLed, inGrid for the current pos)
module grid_axis_cnt #(
  parameter int OFFSET = 10,
  parameter int SIZE = 64,
  parameter int GAP = 10,
  parameter int COUNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pos,
  input  logic       adv,
  output logic [3:0] index,
  output logic       inLed,
  output logic       inGrid
);
  localparam logic [9:0] OFS = 10'(OFFSET);
  localparam logic [9:0] LAST_SUB = 10'(SIZE + GAP - 1);
  localparam logic [9:0] SZ = 10'(SIZE);
  localparam logic [3:0] LAST_IDX = 4'(COUNT - 1);
  logic [3:0] idx_q, idx_d;
  logic [9:0] sub_q, sub_d;
  logic grid_q, grid_d;
  always_comb begin
    idx_d = idx_q;
    sub_d = sub_q;
    grid_d = grid_q;
    if (pos == OFS) begin
      idx_d = '0;
      sub_d = '0;
      grid_d = 1'b1;
    end else if (pos < OFS || !grid_q) grid_d = 1'b0;
    else if (sub_q == LAST_SUB) begin
      sub_d = '0;
      grid_d = idx_q != LAST_IDX;
      idx_d = idx_q + {3'b0, idx_q != LAST_IDX};
    end else sub_d = sub_q + 10'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= '0;
      sub_q <= '0;
      grid_q <= 1'b0;
    end else if (adv) begin
      idx_q <= idx_d;
      sub_q <= sub_d;
      grid_q <= grid_d;
    end
  // without an advance the held state already describes the current pos
  assign index = adv ? idx_d : idx_q;
  assign inGrid = adv ? grid_d : grid_q;
  assign inLed = (adv ? sub_d : sub_q) < SZ;
endmodule

// File: rtl/led_grid_mon.sv
// led_grid_mon: VGA LED-grid debug panel (in: syncGen pos/syncs, LED entry write port, clear pulse; out: 2-cycle registered RGB/syncs, heartbeat o_led)
module led_grid_mon
  import led_grid_pkg::*;
#(
  parameter int NUM_X = 8,
  parameter int NUM_Y = 8,
  parameter int LED_W = 64,
  parameter int LED_H = 50,
  parameter int GAP_X = 10,
  parameter int GAP_Y = 10,
  parameter int OFFSET_X = 10,
  parameter int OFFSET_Y = 10,
  parameter logic [11:0] BG_RGB = 12'h000,
  parameter logic [11:0] OFF_RGB = 12'h222,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        i_clkVideo,
  input  logic        i_reset,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_display_on,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_wrValid,
  input  logic [21:0] i_wrEntry,
  output logic        o_wrReady,
  input  logic        i_clear,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_led
);
  localparam int NUM = NUM_X * NUM_Y;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_d;
  logic [LEDNO_W-1:0] idx, idx_d, s1_idx;
  logic [13:0] entries [2**LEDNO_W];
  logic [13:0] cur;
  logic [BLINK_LOG2:0] frame;
  logic [3:0] col, row;
  logic x_led, y_led, x_grid, y_grid;
  logic s1_in, s1_de, s1_hs, s1_vs;
  logic [11:0] rgb_q, led_rgb;
  ledEntry_t wr;
  ledMode_t cur_mode;
  logic phase, lit, wr_fire;
  assign wr = ledEntry_t'(i_wrEntry);
  assign o_wrReady = state == IDLE;
  assign wr_fire = i_wrValid && o_wrReady;
  assign phase = frame[BLINK_LOG2];
  assign o_led = ~phase;
  always_ff @(posedge i_clkVideo or negedge i_reset)
    if (!i_reset) begin
      state <= CLEAR;
      idx <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
    end
  always_comb begin
    state_d = state;
    idx_d = idx;
    if (i_clear) begin
      state_d = CLEAR;
      idx_d = '0;
    end else if (state == CLEAR) begin
      idx_d = idx + 1'b1;
      state_d = idx == LEDNO_W'(NUM - 1) ? IDLE : CLEAR;
    end
  end
  // out-of-range ledNo is accepted by the handshake but never stored
  always_ff @(posedge i_clkVideo)
    if (state == CLEAR) entries[idx] <= '0;
    else if (wr_fire && {1'b0, wr.ledNo} < (LEDNO_W + 1)'(NUM)) entries[wr.ledNo] <= {wr.mode, wr.rgb};
  always_ff @(posedge i_clkVideo or negedge i_reset)
    if (!i_reset) frame <= '0;
    else frame <= frame + (BLINK_LOG2 + 1)'(i_hpos == 10'd0 && i_vpos == 10'd0);
  grid_axis_cnt #(.OFFSET(OFFSET_X), .SIZE(LED_W), .GAP(GAP_X), .COUNT(NUM_X)) u_x (
    .clk(i_clkVideo), .rst_n(i_reset), .pos(i_hpos), .adv(1'b1),
    .index(col), .inLed(x_led), .inGrid(x_grid)
  );
  // rows only move at the start of each line
  grid_axis_cnt #(.OFFSET(OFFSET_Y), .SIZE(LED_H), .GAP(GAP_Y), .COUNT(NUM_Y)) u_y (
    .clk(i_clkVideo), .rst_n(i_reset), .pos(i_vpos), .adv(i_hpos == 10'd0),
    .index(row), .inLed(y_led), .inGrid(y_grid)
  );
  always_ff @(posedge i_clkVideo or negedge i_reset)
    if (!i_reset) begin
      s1_idx <= '0;
      s1_in <= 1'b0;
      s1_de <= 1'b0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
    end else begin
      s1_idx <= x_grid && y_grid ? LEDNO_W'(row) * LEDNO_W'(NUM_X) + LEDNO_W'(col) : '0;
      s1_in <= x_grid && y_grid && x_led && y_led;
      s1_de <= i_display_on;
      s1_hs <= i_hsync;
      s1_vs <= i_vsync;
    end
  assign cur = entries[s1_idx];
  assign cur_mode = ledMode_t'(cur[13:12]);
  assign lit = cur_mode == ON || (cur_mode == BLINK && phase) || (cur_mode == BLINK_N && !phase);
  assign led_rgb = state == CLEAR || !lit ? OFF_RGB : cur[11:0];
  always_ff @(posedge i_clkVideo or negedge i_reset)
    if (!i_reset) begin
      rgb_q <= '0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
    end else begin
      rgb_q <= !s1_de ? 12'h000 : s1_in ? led_rgb : BG_RGB;
      o_hsync <= s1_hs;
      o_vsync <= s1_vs;
    end
  assign o_red = rgb_q[11:8];
  assign o_green = rgb_q[7:4];
  assign o_blue = rgb_q[3:0];
endmodule

// File: doc/led_grid_mon.md
# led_grid_mon

Parametrised VGA debug panel that draws a NUM_X × NUM_Y grid of virtual LEDs, each with its own 12-bit colour and display mode. Debug sources write LED entries through a valid/ready port, and the block turns the pixel coordinates from an external syncGen into registered RGB and sync outputs. It sits beside the video timing generator and drives the VGA pins directly.

## Interface
- NUM_X, 8, LED columns (1..16)
- NUM_Y, 8, LED rows (1..16); NUM_X*NUM_Y ≤ 256
- LED_W, 64, LED width in pixels
- LED_H, 50, LED height in pixels
- GAP_X, 10, horizontal gap after each LED
- GAP_Y, 10, vertical gap after each LED
- OFFSET_X, 10, first grid pixel column
- OFFSET_Y, 10, first grid pixel row
- BG_RGB, 12'h000, colour of non-LED pixels inside the active display
- OFF_RGB, 12'h222, colour of an LED whose mode is OFF or whose blink phase is dark
- BLINK_LOG2, 5, blink half-period is 2^BLINK_LOG2 frames

Ports:
- i_clkVideo  in  1  pixel clock
- i_reset  in  1  asynchronous, active-low reset
- i_hpos  in  10  pixel column from syncGen
- i_vpos  in  10  pixel row from syncGen
- i_display_on  in  1  active-video flag from syncGen
- i_hsync  in  1  raw hsync from syncGen
- i_vsync  in  1  raw vsync from syncGen
- i_wrValid  in  1  write request
- i_wrEntry  in  22  ledEntry_t: ledNo[21:14], mode[13:12], rgb[11:0]
- o_wrReady  out  1  write accepted when i_wrValid && o_wrReady
- i_clear  in  1  single-cycle pulse that clears all entries
- o_hsync  out  1  hsync delayed to match pixel latency
- o_vsync  out  1  vsync delayed to match pixel latency
- o_red  out  4  pixel red channel
- o_green  out  4  pixel green channel
- o_blue  out  4  pixel blue channel
- o_led  out  1  active-low heartbeat (low while blink phase = 1)

## Operation
- Entry store: NUM_X*NUM_Y registers holding {mode, rgb}.
- Modes:
  - OFF=0: LED shows OFF_RGB.
  - ON=1: LED shows rgb.
  - BLINK=2: LED shows rgb when phase=1, else OFF_RGB.
  - BLINK_N=3: LED shows rgb when phase=0, else OFF_RGB.
- Geometry:
  - TILE_W = LED_W + GAP_X; TILE_H = LED_H + GAP_Y.
  - col = (h − OFFSET_X) / TILE_W; row = (v − OFFSET_Y) / TILE_H.
  - A pixel is inside an LED iff h ≥ OFFSET_X, v ≥ OFFSET_Y, col < NUM_X, row < NUM_Y, (h − OFFSET_X) mod TILE_W < LED_W, and (v − OFFSET_Y) mod TILE_H < LED_H.
  - LED index = row*NUM_X + col, zero-based.
  - No dividers are allowed. Running tile counters must give results identical to the formulas above for every h, v.
- Pixel output:
  - Pixel inside an LED: colour from the mode rules above.
  - Pixel not inside an LED: BG_RGB.
  - Display off: 0.
- Write port:
  - In IDLE, o_wrReady = 1.
  - An accepted write updates entry ledNo with {mode, rgb}.
  - A write with ledNo ≥ NUM_X*NUM_Y is accepted and discarded.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR with idx = 0.
  - In CLEAR: write entry idx to {OFF, 0}, then idx++. Leave for IDLE after idx = NUM_X*NUM_Y − 1.
  - o_wrReady = 0 throughout CLEAR.
  - All LED pixels display OFF_RGB while in CLEAR.
  - i_clear in IDLE → CLEAR, idx = 0, on the next edge.
  - i_clear in CLEAR restarts idx at 0.
  - i_clear together with an accepted write in IDLE: the write completes its handshake, and the clear then wipes it.
- Blink:
  - A frame tick occurs when i_hpos = 0 and i_vpos = 0.
  - The frame counter increments on each tick.
  - phase = frame counter bit BLINK_LOG2.

## Timing
- Pixel latency: 2 cycles.
  - Stage 1 registers LED index, the inside flag, the display_on flag and both syncs.
  - Stage 2 registers RGB and syncs.
- An entry write accepted at edge N is visible to a stage-1 lookup at edge N+1 or later.
- Reset values:
  - o_red, o_green, o_blue = 0.
  - o_hsync, o_vsync = 1.
  - o_wrReady = 0.
  - o_led = 1.
  - Frame counter = 0; FSM = CLEAR, idx = 0.
- Reset asserted mid-operation aborts any clear or write immediately and restarts the clear sequence.
- The frame counter wraps freely.
- The tile counters re-seed at h = OFFSET_X and v = OFFSET_Y, so out-of-range hpos/vpos never produce an index ≥ NUM_X*NUM_Y.

## Structure
- Package led_grid_pkg holds:
  - ledMode_t, the enum OFF/ON/BLINK/BLINK_N.
  - ledEntry_t, a packed struct {ledNo[7:0], mode, rgb[11:0]}.
  - The constant LEDNO_W = 8.
- One sub-module, grid_axis_cnt, is instantiated twice (x and y).
  - Parameters: OFFSET, SIZE, GAP, COUNT.
  - Inputs: position and an advance strobe.
  - Outputs: index, inLed, inGrid.

## Test plan
- Reset, then release:
  - o_wrReady stays 0 for 64 cycles (8×8), then goes to 1.
  - RGB = 0 throughout reset.
- Write ledNo 9, ON, rgb F00, then feed h = 84, v = 70:
  - Two cycles later, o_red = F, o_green = 0, o_blue = 0.
  - Feeding h = 148 (gap) gives BG_RGB.
- Write ledNo 0, BLINK, 0F0, then run 64 frame ticks with BLINK_LOG2 = 5:
  - Pixel (10, 10) shows OFF_RGB for frames 0–31 and 0F0 for frames 32–63.
  - o_led follows the blink phase, low while phase = 1.
- Write ledNo 200 (out of range): the handshake completes and no LED changes.
- Issue i_clear at the same edge as a write to ledNo 5:
  - LED 5 ends as OFF.
  - o_wrReady is low for 64 cycles.
- Drop i_display_on with a lit LED under the beam: RGB = 0 two cycles later, and the syncs still pass through with 2-cycle delay.
